// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_pkg
// Description : Shared pointer-coding helpers and depth derivation for the
//               async FIFO read- and write-side controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

  // Helpers work on a fixed wide vector; callers zero-extend and truncate.
  // Zero upper bits leave both codings unchanged, so any width up to 32 works.
  localparam int unsigned c_fn_width = 32;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  function automatic logic [c_fn_width-1:0] bin2gray(input logic [c_fn_width-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [c_fn_width-1:0] gray2bin(input logic [c_fn_width-1:0] gray);
    logic [c_fn_width-1:0] bin;
    bin[c_fn_width-1] = gray[c_fn_width-1];
    for (int i = c_fn_width - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ff_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff_chain
// Description : Multi-stage flop synchroniser for a Gray-coded bus, async
//               active-low reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2,
  parameter int DLY    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Clock-to-out delay is modelled as zero; the parameter is kept so the
  // instantiation interface matches the rest of the FIFO.
  logic w_unused_dly;
  assign w_unused_dly = (DLY != 0);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_wr_ctrl
// Description : Async FIFO write-side controller: write pointer, read-pointer
//               synchroniser, registered full/almost-full/level, overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl #(
  parameter int DLY         = 1,
  parameter int ADDR_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wr_clk_i,
  input  logic                  wr_rst_n_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_i,
  input  logic [ADDR_WIDTH:0]   afull_thresh_i,
  input  logic                  ovf_clr_i,
  output logic                  wr_accept_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic [ADDR_WIDTH:0]   wr_level_o,
  output logic                  overflow_o
);

  import async_fifo_pkg::*;

  localparam int c_ptr_w = ADDR_WIDTH + 1;

  logic [ADDR_WIDTH:0] r_wr_bin;
  logic [ADDR_WIDTH:0] r_wr_gray;
  logic [ADDR_WIDTH:0] r_level;
  logic                r_full;
  logic                r_afull;
  logic                r_ovf;

  logic [ADDR_WIDTH:0] w_rd_gray_sync;
  logic [ADDR_WIDTH:0] w_rd_bin_sync;
  logic [ADDR_WIDTH:0] w_wr_bin_next;
  logic [ADDR_WIDTH:0] w_wr_gray_next;
  logic [ADDR_WIDTH:0] w_level_next;
  logic [ADDR_WIDTH:0] w_full_gray;
  logic                w_full_next;
  logic                w_push;

  sync_ff_chain #(
    .WIDTH  (c_ptr_w),
    .STAGES (SYNC_STAGES),
    .DLY    (DLY)
  ) u_rd_ptr_sync (
    .clk   (wr_clk_i),
    .rst_n (wr_rst_n_i),
    .i_d   (rd_ptr_gray_i),
    .o_q   (w_rd_gray_sync)
  );

  // Gated by reset so nothing reaches the RAM while the controller is held.
  assign w_push = wr_en_i & ~r_full & wr_rst_n_i;

  assign w_rd_bin_sync  = c_ptr_w'(gray2bin(c_fn_width'(w_rd_gray_sync)));
  assign w_wr_bin_next  = r_wr_bin + {{ADDR_WIDTH{1'b0}}, w_push};
  assign w_wr_gray_next = c_ptr_w'(bin2gray(c_fn_width'(w_wr_bin_next)));
  assign w_level_next   = w_wr_bin_next - w_rd_bin_sync;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits
  // inverted, the rest equal.
  assign w_full_gray = {~w_rd_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1],
                        w_rd_gray_sync[ADDR_WIDTH-2:0]};
  assign w_full_next = (w_wr_gray_next == w_full_gray);

  always_ff @(posedge wr_clk_i or negedge wr_rst_n_i) begin
    if (!wr_rst_n_i) begin
      r_wr_bin  <= '0;
      r_wr_gray <= '0;
      r_level   <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_bin  <= w_wr_bin_next;
      r_wr_gray <= w_wr_gray_next;
      r_level   <= w_level_next;
      r_full    <= w_full_next;
      r_afull   <= (w_level_next >= afull_thresh_i);
      // Set wins over a coincident clear.
      r_ovf     <= (wr_en_i & r_full) | (r_ovf & ~ovf_clr_i);
    end
  end

  assign wr_accept_o   = w_push;
  assign wr_addr_o     = r_wr_bin[ADDR_WIDTH-1:0];
  assign wr_ptr_gray_o = r_wr_gray;
  assign full_o        = r_full;
  assign almost_full_o = r_afull;
  assign wr_level_o    = r_level;
  assign overflow_o    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_wr_ctrl
// Description : Directed self-checking bench for async_fifo_wr_ctrl
//               (ADDR_WIDTH=3, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;

  localparam int ADDR_WIDTH  = 3;
  localparam int SYNC_STAGES = 2;

  logic       wr_clk_i;
  logic       wr_rst_n_i;
  logic       wr_en_i;
  logic [3:0] rd_ptr_gray_i;
  logic [3:0] afull_thresh_i;
  logic       ovf_clr_i;
  logic       wr_accept_o;
  logic [2:0] wr_addr_o;
  logic [3:0] wr_ptr_gray_o;
  logic       full_o;
  logic       almost_full_o;
  logic [3:0] wr_level_o;
  logic       overflow_o;

  int n_cmp;
  int n_err;

  async_fifo_wr_ctrl #(
    .DLY         (1),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .wr_clk_i       (wr_clk_i),
    .wr_rst_n_i     (wr_rst_n_i),
    .wr_en_i        (wr_en_i),
    .rd_ptr_gray_i  (rd_ptr_gray_i),
    .afull_thresh_i (afull_thresh_i),
    .ovf_clr_i      (ovf_clr_i),
    .wr_accept_o    (wr_accept_o),
    .wr_addr_o      (wr_addr_o),
    .wr_ptr_gray_o  (wr_ptr_gray_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .wr_level_o     (wr_level_o),
    .overflow_o     (overflow_o)
  );

  initial wr_clk_i = 1'b0;
  always #5 wr_clk_i = ~wr_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge wr_clk_i);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_accept"}, wr_accept_o, 0);
    chk({tag, "_addr"},   wr_addr_o, 0);
    chk({tag, "_gray"},   wr_ptr_gray_o, 0);
    chk({tag, "_full"},   full_o, 0);
    chk({tag, "_afull"},  almost_full_o, 0);
    chk({tag, "_level"},  wr_level_o, 0);
    chk({tag, "_ovf"},    overflow_o, 0);
  endtask

  logic [3:0] m_wr_bin;
  logic [3:0] m_rd_bin;
  logic [3:0] m_gray;
  logic [3:0] prev_gray;

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    wr_rst_n_i     = 1'b0;
    wr_en_i        = 1'b1;
    rd_ptr_gray_i  = 4'd0;
    afull_thresh_i = 4'd6;
    ovf_clr_i      = 1'b0;

    // Reset held with a write request pending
    tick();
    tick();
    chk_all_zero("rst");
    wr_rst_n_i = 1'b1;
    #1;
    chk("rel_accept", wr_accept_o, 1);

    // Eight back-to-back pushes into an empty FIFO
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("fill_level", wr_level_o, k);
      chk("fill_afull", almost_full_o, (k >= 6) ? 1 : 0);
      chk("fill_full",  full_o, (k == 8) ? 1 : 0);
    end
    chk("full_addr", wr_addr_o, 0);
    chk("full_gray", wr_ptr_gray_o, 4'b1100);

    // Request while full is dropped and sets overflow
    chk("full_accept", wr_accept_o, 0);
    tick();
    chk("ovf_set",   overflow_o, 1);
    chk("ovf_gray",  wr_ptr_gray_o, 4'b1100);
    chk("ovf_addr",  wr_addr_o, 0);
    chk("ovf_level", wr_level_o, 8);
    ovf_clr_i = 1'b1;
    tick();
    chk("ovf_set_wins", overflow_o, 1);
    wr_en_i = 1'b0;
    tick();
    chk("ovf_clr", overflow_o, 0);
    ovf_clr_i = 1'b0;

    // One read: full drops after SYNC_STAGES+1 edges
    rd_ptr_gray_i = 4'b0001;
    tick();
    chk("rd_e1_full",  full_o, 1);
    chk("rd_e1_level", wr_level_o, 8);
    tick();
    chk("rd_e2_full",  full_o, 1);
    chk("rd_e2_level", wr_level_o, 8);
    tick();
    chk("rd_e3_full",  full_o, 0);
    chk("rd_e3_level", wr_level_o, 7);
    chk("rd_e3_afull", almost_full_o, 1);

    // Threshold above DEPTH never sets almost-full, even when full
    afull_thresh_i = 4'd9;
    chk("t9_accept", wr_accept_o, 0);
    wr_en_i = 1'b1;
    #1;
    chk("t9_accept_en", wr_accept_o, 1);
    tick();
    wr_en_i = 1'b0;
    chk("t9_level", wr_level_o, 8);
    chk("t9_full",  full_o, 1);
    chk("t9_afull", almost_full_o, 0);

    // Asynchronous reset, then threshold 0 sets almost-full on first edge
    #1;
    wr_rst_n_i = 1'b0;
    #1;
    chk_all_zero("arst1");
    rd_ptr_gray_i  = 4'd0;
    afull_thresh_i = 4'd0;
    tick();
    wr_rst_n_i = 1'b1;
    #1;
    chk("t0_before", almost_full_o, 0);
    tick();
    chk("t0_afull", almost_full_o, 1);
    chk("t0_level", wr_level_o, 0);
    afull_thresh_i = 4'd6;

    // Prime level 4, then concurrent push/read across the pointer wrap
    wr_en_i  = 1'b1;
    m_wr_bin = 4'd0;
    m_rd_bin = 4'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      m_wr_bin = m_wr_bin + 4'd1;
    end
    chk("prime_level", wr_level_o, 4);
    prev_gray = wr_ptr_gray_o;
    for (int j = 1; j <= 20; j++) begin
      m_rd_bin      = m_rd_bin + 4'd1;
      rd_ptr_gray_i = m_rd_bin ^ (m_rd_bin >> 1);
      tick();
      m_wr_bin = m_wr_bin + 4'd1;
      m_gray   = m_wr_bin ^ (m_wr_bin >> 1);
      chk("wrap_gray",   wr_ptr_gray_o, m_gray);
      chk("wrap_1bit",   $countones(wr_ptr_gray_o ^ prev_gray), 1);
      chk("wrap_addr",   wr_addr_o, m_wr_bin[2:0]);
      chk("wrap_full",   full_o, 0);
      prev_gray = wr_ptr_gray_o;
    end

    // Let the read pointer settle (level 4), push once to level 5
    wr_en_i = 1'b0;
    tick();
    tick();
    tick();
    chk("settle_level", wr_level_o, 4);
    wr_en_i = 1'b1;
    tick();
    wr_en_i = 1'b0;
    chk("lvl5_level", wr_level_o, 5);

    // Mid-cycle asynchronous reset clears everything before the next edge
    #1;
    wr_rst_n_i = 1'b0;
    #1;
    chk_all_zero("arst2");
    rd_ptr_gray_i = 4'd0;
    tick();
    wr_en_i    = 1'b1;
    wr_rst_n_i = 1'b1;
    #1;
    chk("post_accept", wr_accept_o, 1);
    chk("post_addr0",  wr_addr_o, 0);
    tick();
    wr_en_i = 1'b0;
    chk("post_addr1",  wr_addr_o, 1);
    chk("post_level",  wr_level_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
